// File: rtl/full_adder.sv
// Ripple-carry adder assembled from an array of 1-bit full-adder cells, with an
// optional in_valid-qualified output register stage.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid,
    output logic             ovf
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_comb;
    logic             ovf_comb;

    assign c[0] = c_in;

    fa_bit u_fa [WIDTH-1:0] (
        .a     (a),
        .b     (b),
        .c_in  (c[WIDTH-1:0]),
        .s     (s_comb),
        .c_out (c[WIDTH:1])
    );

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_comb = c[WIDTH] ^ c[WIDTH-1];

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum       <= '0;
                c_out     <= 1'b0;
                ovf       <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    sum   <= s_comb;
                    c_out <= c[WIDTH];
                    ovf   <= ovf_comb;
                end
            end
        end
    end else begin : g_comb
        assign sum       = s_comb;
        assign c_out     = c[WIDTH];
        assign ovf       = ovf_comb;
        assign out_valid = in_valid;

        // Clock and reset have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
    end
endmodule

module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: 1-bit and 8-bit builds, combinational and registered,
// checked against an arithmetic reference model.
module tb_full_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic       cin, vld;

    logic       s1c, co1c, v1c, ov1c;
    logic       s1r, co1r, v1r, ov1r;
    logic [7:0] s8r, s8c;
    logic       co8r, v8r, ov8r, co8c, v8c, ov8c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .REG_OUT(0)) u1c (.clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(cin),
        .in_valid(vld), .sum(s1c), .c_out(co1c), .out_valid(v1c), .ovf(ov1c));
    full_adder #(.WIDTH(1), .REG_OUT(1)) u1r (.clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(cin),
        .in_valid(vld), .sum(s1r), .c_out(co1r), .out_valid(v1r), .ovf(ov1r));
    full_adder #(.WIDTH(8), .REG_OUT(1)) u8r (.clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(cin),
        .in_valid(vld), .sum(s8r), .c_out(co8r), .out_valid(v8r), .ovf(ov8r));
    full_adder #(.WIDTH(8), .REG_OUT(0)) u8c (.clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(cin),
        .in_valid(vld), .sum(s8c), .c_out(co8c), .out_valid(v8c), .ovf(ov8c));

    // Reference: {ovf, c_out, sum[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        int   t;
        logic ov;
        t  = int'(x) + int'(y) + int'(ci);
        ov = (x[7] == y[7]) && (((t >> 7) & 1) != int'(x[7]));
        return {ov, t[8], t[7:0]};
    endfunction

    // Reference: {ovf, c_out, sum} for the 1-bit build.
    function automatic logic [2:0] model1(input logic x, input logic y, input logic ci);
        int t;
        t = int'(x) + int'(y) + int'(ci);
        return {ci ^ t[1], t[1], t[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic v);
        a8 = x; b8 = y; cin = ci; vld = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive8(8'h5A, 8'hC3, 1'b1, 1'b1);
        a1 = 1'b1; b1 = 1'b1;
        step(); step();
        checks++;
        if ({v8r, ov8r, co8r, s8r} !== 11'd0) begin
            errors++;
            $display("FAIL reset_w8 got %h want 000", {v8r, ov8r, co8r, s8r});
        end
        checks++;
        if ({v1r, ov1r, co1r, s1r} !== 4'd0) begin
            errors++;
            $display("FAIL reset_w1 got %b want 0000", {v1r, ov1r, co1r, s1r});
        end
        // The combinational build ignores reset entirely.
        checks++;
        if ({v8c, ov8c, co8c, s8c} !== {1'b1, model8(8'h5A, 8'hC3, 1'b1)}) begin
            errors++;
            $display("FAIL comb_ignores_rst got %h want %h", {v8c, ov8c, co8c, s8c},
                     {1'b1, model8(8'h5A, 8'hC3, 1'b1)});
        end
        rst = 1'b0;
        drive8(8'h12, 8'h34, 1'b0, 1'b1);
        step();
        checks++;
        if ({v8r, ov8r, co8r, s8r} !== {1'b1, model8(8'h12, 8'h34, 1'b0)}) begin
            errors++;
            $display("FAIL first_after_reset got %h want %h", {v8r, ov8r, co8r, s8r},
                     {1'b1, model8(8'h12, 8'h34, 1'b0)});
        end
        vld = 1'b0;
        step();
    endtask

    // Hand-tabulated truth table for the 1-bit adder, indexed by {a,b,c_in}.
    logic [1:0] tt_sc [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    task automatic test_sweep_comb();
        vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            {a1, b1, cin} = v;
            #10;
            checks++;
            if ({s1c, co1c} !== tt_sc[k] || ov1c !== (cin ^ tt_sc[k][0]) || v1c !== 1'b1) begin
                errors++;
                $display("FAIL sweep_comb[%0d] got s/c/ovf/v %b%b%b%b want %b%b%b1", k, s1c, co1c,
                         ov1c, v1c, tt_sc[k][1], tt_sc[k][0], cin ^ tt_sc[k][0]);
            end
        end
        vld = 1'b0;
        step();
    endtask

    task automatic test_sweep_reg();
        logic [2:0] q [$];
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                logic [2:0] e;
                logic [1:0] sc;
                e  = q.pop_front();
                sc = tt_sc[e];
                checks++;
                if ({s1r, co1r, v1r} !== {sc, 1'b1} || ov1r !== (e[0] ^ sc[0])) begin
                    errors++;
                    $display("FAIL sweep_reg[%0d] got s/c/v/ovf %b%b%b%b want %b%b1%b", k - 1,
                             s1r, co1r, v1r, ov1r, sc[1], sc[0], e[0] ^ sc[0]);
                end
            end
            if (k < 8) begin
                logic [2:0] v;
                v = 3'(k);
                {a1, b1, cin} = v;
                vld = 1'b1;
                q.push_back(v);
            end else begin
                vld = 1'b0;
            end
            step();
        end
        checks++;
        if (v1r !== 1'b0) begin
            errors++;
            $display("FAIL sweep_reg_tail out_valid got %b want 0", v1r);
        end
    endtask

    task automatic test_corners();
        logic [7:0] ca [3] = '{8'hFF, 8'h7F, 8'hFF};
        logic [7:0] cb [3] = '{8'h00, 8'h01, 8'hFF};
        logic       cc [3] = '{1'b1, 1'b0, 1'b1};
        logic [9:0] ce [3] = '{10'b0_1_00000000, 10'b1_0_10000000, 10'b0_1_11111111};
        for (int k = 0; k < 3; k++) begin
            drive8(ca[k], cb[k], cc[k], 1'b1);
            #1;
            checks++;
            if ({ov8c, co8c, s8c} !== ce[k]) begin
                errors++;
                $display("FAIL corner_comb[%0d] got %h want %h", k, {ov8c, co8c, s8c}, ce[k]);
            end
            step();
            checks++;
            if ({v8r, ov8r, co8r, s8r} !== {1'b1, ce[k]}) begin
                errors++;
                $display("FAIL corner_reg[%0d] got %h want %h", k, {v8r, ov8r, co8r, s8r},
                         {1'b1, ce[k]});
            end
        end
        vld = 1'b0;
        step();
    endtask

    task automatic test_exhaustive8();
        vld = 1'b0;
        for (int k = 0; k < (1 << 17); k++) begin
            logic [16:0] v;
            v = 17'(k);
            {a8, b8, cin} = v;
            #1;
            checks++;
            if ({v8c, ov8c, co8c, s8c} !== {1'b0, model8(v[16:9], v[8:1], v[0])}) begin
                errors++;
                $display("FAIL exhaustive8 a=%h b=%h ci=%b got %h want %h", v[16:9], v[8:1], v[0],
                         {v8c, ov8c, co8c, s8c}, {1'b0, model8(v[16:9], v[8:1], v[0])});
            end
        end
        step();
    endtask

    task automatic test_gap();
        logic [9:0] e1, e2;
        drive8(8'h3C, 8'h44, 1'b1, 1'b1);
        e1 = model8(8'h3C, 8'h44, 1'b1);
        step();
        checks++;
        if ({v8r, ov8r, co8r, s8r} !== {1'b1, e1}) begin
            errors++;
            $display("FAIL gap_first got %h want %h", {v8r, ov8r, co8r, s8r}, {1'b1, e1});
        end
        drive8(8'hA7, 8'hE9, 1'b0, 1'b0);
        step();
        checks++;
        if ({v8r, ov8r, co8r, s8r} !== {1'b0, e1}) begin
            errors++;
            $display("FAIL gap_hold got %h want %h", {v8r, ov8r, co8r, s8r}, {1'b0, e1});
        end
        drive8(8'h80, 8'h80, 1'b0, 1'b1);
        e2 = model8(8'h80, 8'h80, 1'b0);
        step();
        checks++;
        if ({v8r, ov8r, co8r, s8r} !== {1'b1, e2}) begin
            errors++;
            $display("FAIL gap_second got %h want %h", {v8r, ov8r, co8r, s8r}, {1'b1, e2});
        end
        vld = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        logic [9:0] e;
        drive8(8'h11, 8'h22, 1'b0, 1'b1);
        step();
        drive8(8'h99, 8'h99, 1'b1, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({v8r, ov8r, co8r, s8r} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_async got %h want 000", {v8r, ov8r, co8r, s8r});
        end
        step();
        rst = 1'b0;
        vld = 1'b0;
        step();
        checks++;
        if ({v8r, ov8r, co8r, s8r} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_no_stale got %h want 000", {v8r, ov8r, co8r, s8r});
        end
        drive8(8'hF0, 8'h0F, 1'b1, 1'b1);
        e = model8(8'hF0, 8'h0F, 1'b1);
        step();
        checks++;
        if ({v8r, ov8r, co8r, s8r} !== {1'b1, e}) begin
            errors++;
            $display("FAIL mid_reset_resume got %h want %h", {v8r, ov8r, co8r, s8r}, {1'b1, e});
        end
        vld = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [9:0] hold;
        logic       exp_v;
        hold  = {v8r ? 1'b0 : 1'b0, 9'd0};
        hold  = model8(8'hF0, 8'h0F, 1'b1);
        exp_v = 1'b0;
        for (int k = 0; k < 300; k++) begin
            logic [7:0] x, y;
            logic       ci, v;
            x  = 8'($urandom);
            y  = 8'($urandom);
            ci = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            drive8(x, y, ci, v);
            #1;
            checks++;
            if ({v8c, ov8c, co8c, s8c} !== {v, model8(x, y, ci)}) begin
                errors++;
                $display("FAIL random_comb[%0d] got %h want %h", k, {v8c, ov8c, co8c, s8c},
                         {v, model8(x, y, ci)});
            end
            if (v) hold = model8(x, y, ci);
            exp_v = v;
            step();
            checks++;
            if ({v8r, ov8r, co8r, s8r} !== {exp_v, hold}) begin
                errors++;
                $display("FAIL random_reg[%0d] got %h want %h", k, {v8r, ov8r, co8r, s8r},
                         {exp_v, hold});
            end
        end
        vld = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        drive8(8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        test_reset();
        test_sweep_comb();
        test_sweep_reg();
        test_corners();
        test_gap();
        test_mid_reset();
        test_random();
        test_exhaustive8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1, sets the operand width in bits; legal range 1..64.
REQ-002 Parameter REG_OUT, default 1: 1 = registered outputs with 1-cycle latency; 0 = purely combinational outputs.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a  input  WIDTH  operand A, unsigned.
REQ-006 b  input  WIDTH  operand B, unsigned.
REQ-007 c_in  input  1  carry-in.
REQ-008 in_valid  input  1  qualifies a, b and c_in in the current cycle.
REQ-009 sum  output  WIDTH  low WIDTH bits of a+b+c_in.
REQ-010 c_out  output  1  carry-out, bit WIDTH of a+b+c_in.
REQ-011 out_valid  output  1  qualifies sum, c_out and ovf.
REQ-012 ovf  output  1  signed-overflow flag: carry into MSB XOR carry out of MSB.
REQ-013 Ports SHALL be connected by name; positional order is not guaranteed.

Function
REQ-014 Each bit stage SHALL compute s_i = a_i ^ b_i ^ c_i and c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i, with c_0 = c_in.
REQ-015 The chain SHALL be built from WIDTH explicit 1-bit full-adder stages (ripple carry), not a behavioural '+'.
REQ-016 {c_out, sum} SHALL equal a + b + c_in exactly, for all 2^(2*WIDTH+1) input combinations.
REQ-017 When WIDTH = 1, ovf SHALL equal c_in ^ c_out.
REQ-018 When REG_OUT = 1, each rising clk edge with in_valid = 1 SHALL capture sum, c_out and ovf; out_valid SHALL be 1 in the following cycle.
REQ-019 When REG_OUT = 1 and in_valid = 0 at an edge, sum, c_out and ovf SHALL hold their previous values and out_valid SHALL be 0.
REQ-020 When REG_OUT = 1, latency SHALL be exactly 1 cycle and throughput 1 result per cycle; back-to-back valid inputs SHALL all be produced in order.
REQ-021 When REG_OUT = 0, sum, c_out and ovf SHALL follow the inputs combinationally, out_valid SHALL equal in_valid, and clk and rst SHALL be ignored.
REQ-022 X or Z on an input SHALL NOT corrupt any held register while in_valid = 0.

Reset
REQ-023 When rst is asserted, asynchronously and without waiting for clk, sum SHALL be 0, c_out 0, ovf 0 and out_valid 0 (REG_OUT = 1).
REQ-024 While rst = 1, inputs SHALL be ignored, including when in_valid = 1.
REQ-025 After rst deasserts, the first rising edge with in_valid = 1 SHALL produce a valid result one cycle later.
REQ-026 Asserting rst mid-stream SHALL discard any result not yet presented; no stale out_valid SHALL appear after release.

Verification
REQ-027 WIDTH=1, REG_OUT=0, exhaustive sweep of a,b,c_in from 000 to 111, 10 ns apart -> sum/c_out = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
REQ-028 WIDTH=1, REG_OUT=1, the same 8 vectors back-to-back with in_valid = 1 -> identical sum/c_out pairs, each one cycle later, with out_valid high for 8 consecutive cycles.
REQ-029 WIDTH=8, a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1, ovf=0; then a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, ovf=1.
REQ-030 WIDTH=8, a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-031 Assert rst between clock edges while out_valid = 1 -> sum, c_out, ovf and out_valid go to 0 immediately; the first valid input after release appears exactly 1 cycle later.
REQ-032 in_valid toggling 1,0,1 with distinct operands -> out_valid toggles 1,0,1 one cycle later, and outputs hold their values during the gap.
